rf_writeback: RTL and testbench

Write-side front end for the 32x32 integer register file. It collects writeback results from two producers, the ALU pipe and the load-response path, and queues them in a small in-order FIFO. It drains one entry per cycle into the register file's write port (write enable, address, data, pc). It also reports whether a register a reader wants to read still has a write pending, so decode can stall.

---
 rtl/rf_writeback.sv | 126 ++++++++++++
 tb/tb_rf_writeback.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// rf_writeback: merges ALU and load writebacks into an in-order FIFO
// and drains one entry per cycle into the register-file write port.
module rf_writeback #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_addr,
  input  logic [31:0]             alu_data,
  input  logic [ADDR_W-1:0]       alu_pc,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [4:0]              ld_addr,
  input  logic [31:0]             ld_data,
  input  logic [ADDR_W-1:0]       ld_pc,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [ADDR_W-1:0]       rf_pc,
  input  logic [4:0]              rd_addr1,
  input  logic [4:0]              rd_addr2,
  output logic                    pend1,
  output logic                    pend2,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]        addr;
    logic [31:0]       data;
    logic [ADDR_W-1:0] pc;
  } ent_t;

  ent_t            r_mem [DEPTH];
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;

  logic [CW-1:0]   w_free;
  logic            w_ld_push;
  logic            w_alu_push;
  logic            w_pop;
  logic [1:0]      w_npush;
  logic [PW-1:0]   w_alu_slot;
  ent_t            w_head;
  ent_t            w_ld_ent;
  ent_t            w_alu_ent;
  logic            w_hit1;
  logic            w_hit2;
  logic [PW-1:0]   w_off;

  // Loads own the last free slot; readiness never looks at this cycle's pop.
  assign w_free    = CW'(DEPTH) - r_count;
  assign ld_ready  = (w_free >= CW'(1));
  assign alu_ready = (w_free >= CW'(2)) ||
                     ((w_free == CW'(1)) && !ld_valid);

  assign w_ld_push  = ld_valid && ld_ready && (ld_addr != 5'd0);
  assign w_alu_push = alu_valid && alu_ready && (alu_addr != 5'd0);
  assign w_pop      = (r_count != '0);
  assign w_npush    = {1'b0, w_ld_push} + {1'b0, w_alu_push};
  assign w_alu_slot = r_wptr + PW'(w_ld_push);

  assign w_head    = r_mem[r_rptr];
  assign w_ld_ent  = '{addr: ld_addr, data: ld_data, pc: ld_pc};
  assign w_alu_ent = '{addr: alu_addr, data: alu_data, pc: alu_pc};

  always_ff @(posedge clk) begin
    if (w_ld_push)
      r_mem[r_wptr] <= w_ld_ent;
    if (w_alu_push)
      r_mem[w_alu_slot] <= w_alu_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_count  <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_pc    <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_npush);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count + CW'(w_npush) - CW'(w_pop);
      rf_we   <= w_pop;
      if (w_pop) begin
        rf_waddr <= w_head.addr;
        rf_wdata <= w_head.data;
        rf_pc    <= w_head.pc;
      end
    end
  end

  // Output register counts as pending: the RF commits it on the negedge.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rptr;
      if ({1'b0, w_off} < r_count) begin
        if (r_mem[i].addr == rd_addr1)
          w_hit1 = 1'b1;
        if (r_mem[i].addr == rd_addr2)
          w_hit2 = 1'b1;
      end
    end
    if (rf_we && (rf_waddr == rd_addr1))
      w_hit1 = 1'b1;
    if (rf_we && (rf_waddr == rd_addr2))
      w_hit2 = 1'b1;
  end

  assign pend1 = (rd_addr1 != 5'd0) && w_hit1;
  assign pend2 = (rd_addr2 != 5'd0) && w_hit2;
  assign count = r_count;

endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: scoreboard bench for rf_writeback; a queue model
// tracks occupancy, readiness, pending state and write order.
module tb_rf_writeback;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic [31:0] alu_pc = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] ld_pc = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_pc;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        pend1;
  logic        pend2;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  ent_t        sb[$];
  ent_t        mf[$];
  logic        mwe = 1'b0;
  logic [4:0]  maddr = '0;
  ent_t        me;

  rf_writeback #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data), .alu_pc(alu_pc),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_pc(ld_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_pc(rf_pc),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .pend1(pend1), .pend2(pend2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic mpend(input logic [4:0] a);
    logic hit;
    hit = mwe && (maddr == a);
    foreach (mf[i])
      if (mf[i].a == a) hit = 1'b1;
    return (a != 5'd0) && hit;
  endfunction

  // One cycle: drive just after negedge, check, let the posedge act.
  task automatic step(input logic lv, input logic [4:0] la,
                      input logic [31:0] ldt, input logic [31:0] lp,
                      input logic av, input logic [4:0] aa,
                      input logic [31:0] adt, input logic [31:0] ap);
    int   fr;
    logic lr;
    logic ar;
    ent_t e;
    ld_valid = lv;  ld_addr = la;  ld_data = ldt;  ld_pc = lp;
    alu_valid = av; alu_addr = aa; alu_data = adt; alu_pc = ap;
    #1;
    fr = DEPTH - mf.size();
    lr = (fr >= 1);
    ar = (fr >= 2) || (fr == 1 && !lv);
    check("ld_ready", 64'(ld_ready), 64'(lr));
    check("alu_ready", 64'(alu_ready), 64'(ar));
    check("count", 64'(count), 64'(mf.size()));
    check("rf_we", 64'(rf_we), 64'(mwe));
    if (mwe) check("rf_waddr_now", 64'(rf_waddr), 64'(maddr));
    check("pend1", 64'(pend1), 64'(mpend(rd_addr1)));
    check("pend2", 64'(pend2), 64'(mpend(rd_addr2)));
    @(posedge clk);
    if (mf.size() != 0) begin
      e = mf.pop_front();
      mwe = 1'b1;
      maddr = e.a;
    end else begin
      mwe = 1'b0;
    end
    if (lv && lr && la != 5'd0) begin
      e = '{a: la, d: ldt, p: lp};
      mf.push_back(e);
      sb.push_back(e);
    end
    if (av && ar && aa != 5'd0) begin
      e = '{a: aa, d: adt, p: ap};
      mf.push_back(e);
      sb.push_back(e);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    assert (count <= 3'(DEPTH))
      else check("overflow", 64'(count), 64'(DEPTH));
    if (rst_n && rf_we) begin
      if (sb.size() == 0) begin
        check("spurious_we", 64'(rf_waddr), 64'h0);
      end else begin
        me = sb.pop_front();
        check("wr_addr", 64'(rf_waddr), 64'(me.a));
        check("wr_data", 64'(rf_wdata), 64'(me.d));
        check("wr_pc", 64'(rf_pc), 64'(me.p));
      end
    end
  end

  initial begin
    #1;
    check("rst_we", 64'(rf_we), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_ld_ready", 64'(ld_ready), 64'h1);
    check("rst_alu_ready", 64'(alu_ready), 64'h1);
    check("rst_waddr", 64'(rf_waddr), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write with pending tracking on r5
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd6;
    step(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 32'h1C);
    idle(3);

    // Simultaneous producers: load first, then ALU
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd4;
    step(1, 5'd3, 32'h11, 32'h100, 1, 5'd4, 32'h22, 32'h104);
    idle(3);

    // Continuous ALU stream
    rd_addr1 = 5'd12;
    rd_addr2 = 5'd15;
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 0, 1, 5'(10 + i), 32'h100 + i, 32'h40 + 4 * i);
    idle(2);

    // Fill to DEPTH-1, then contend for the last slot
    rd_addr1 = 5'd16;
    rd_addr2 = 5'd17;
    step(1, 5'd6, 32'hA6, 32'h200, 1, 5'd7, 32'hA7, 32'h204);
    step(1, 5'd8, 32'hA8, 32'h208, 1, 5'd9, 32'hA9, 32'h20C);
    step(1, 5'd16, 32'hB0, 32'h210, 1, 5'd17, 32'hB1, 32'h214);
    step(0, 0, 0, 0, 1, 5'd17, 32'hB1, 32'h214);
    idle(6);

    // Address 0 is acknowledged but dropped
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    step(0, 0, 0, 0, 1, 5'd0, 32'h55, 32'h300);
    idle(3);

    // Asynchronous reset while draining
    rd_addr1 = 5'd20;
    rd_addr2 = 5'd22;
    step(1, 5'd20, 32'hC0, 32'h400, 1, 5'd21, 32'hC1, 32'h404);
    step(1, 5'd22, 32'hC2, 32'h408, 1, 5'd23, 32'hC3, 32'h40C);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 64'(rf_we), 64'h0);
    check("mid_rst_count", 64'(count), 64'h0);
    check("mid_rst_pend1", 64'(pend1), 64'h0);
    check("mid_rst_pend2", 64'(pend2), 64'h0);
    check("mid_rst_ld_ready", 64'(ld_ready), 64'h1);
    mf.delete();
    sb.delete();
    mwe = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    idle(4);

    // Post-reset traffic still flows
    rd_addr1 = 5'd30;
    rd_addr2 = 5'd31;
    step(1, 5'd30, 32'hE0, 32'h500, 1, 5'd31, 32'hE1, 32'h504);
    idle(4);

    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
